// File: rtl/fdown_pkg.sv
// Shared types and constants for the fDown per-frame game controller.
package fdown_pkg;

  typedef enum logic [2:0] {
    ST_WAIT, ST_IDLE, ST_SCROLL, ST_MOVE, ST_LAND, ST_OVER
  } state_t;

  localparam int NUM_FLOORS     = 3;
  localparam int CW             = 10;   // coordinate width
  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int RESPAWN_PERIOD = 450;
  localparam int GAP_MIN        = 32;

  localparam logic [CW-1:0] X_INIT = 10'd320;
  localparam logic [CW-1:0] Y_INIT = 10'd240;
  localparam logic [CW-1:0] FLOOR_INIT [NUM_FLOORS] = '{10'd100, 10'd250, 10'd400};
  localparam logic [CW-1:0] GAPX_INIT  [NUM_FLOORS] = '{10'd200, 10'd300, 10'd150};
  localparam logic [CW-1:0] GAPW_INIT  [NUM_FLOORS] = '{10'd40,  10'd35,  10'd60};

  // Floor 0 sits in the top field of each 30-bit packed output.
  localparam int FLD0_HI = 29, FLD0_LO = 20;
  localparam int FLD1_HI = 19, FLD1_LO = 10;
  localparam int FLD2_HI = 9,  FLD2_LO = 0;

  // One left shift of the x^16+x^14+x^13+x^11+1 Fibonacci LFSR.
  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Gap bits n shifts ahead of s; n is a loop constant at every call site.
  function automatic logic [11:0] lfsrAhead(input logic [15:0] s, input int n);
    logic [15:0] t;
    t = s;
    for (int k = 0; k < n; k++) t = lfsrStep(t);
    return t[11:0];
  endfunction

endpackage

// File: rtl/fdown_lfsr16.sv
// 16-bit Fibonacci LFSR with advance enable and synchronous load.
module fdown_lfsr16
  import fdown_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  input  logic        load,
  input  logic [15:0] loadVal,
  output logic [15:0] state
);

  // Load has priority over advance; reset returns to the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    state <= SEED;
    else if (load) state <= loadVal;
    else if (adv)  state <= lfsrStep(state);
  end

endmodule

// File: rtl/fdown_ctrl.sv
// Per-frame fDown controller: scroll floors, move ball, apply gravity/landing.
module fdown_ctrl
  import fdown_pkg::*;
#(
  parameter int          SCROLL_STEP = 1,
  parameter int          FALL_STEP   = 2,
  parameter int          MOVE_STEP   = 2,
  parameter int          BALL_R      = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame,
  input  logic                     start,
  input  logic                     btn_left,
  input  logic                     btn_right,
  output logic [CW-1:0]            x_pos,
  output logic [CW-1:0]            y_pos,
  output logic [NUM_FLOORS*CW-1:0] floors_y,
  output logic [NUM_FLOORS*CW-1:0] gaps_x,
  output logic [NUM_FLOORS*CW-1:0] gaps_w,
  output logic                     game_over,
  output logic [15:0]              score
);

  localparam logic [10:0] X_MAX = 11'(SCREEN_W - 1 - BALL_R);
  localparam logic [10:0] Y_MAX = 11'(SCREEN_H - 1 - BALL_R);

  state_t        st;
  logic [15:0]   lfsr;
  logic [CW-1:0] fy [NUM_FLOORS];
  logic [CW-1:0] gx [NUM_FLOORS];
  logic [CW-1:0] gw [NUM_FLOORS];

  logic [CW-1:0] fyScr [NUM_FLOORS];
  logic [CW-1:0] gxScr [NUM_FLOORS];
  logic [CW-1:0] gwScr [NUM_FLOORS];
  logic [11:0]   gapBits [NUM_FLOORS];
  logic [1:0]    nResp;
  logic [16:0]   scoreSum;
  logic [15:0]   scoreNext;

  logic [10:0]   xw, bw, yw;
  logic [CW-1:0] xMove, yLand, hitFy;
  logic          hit, overGap, landOver;

  fdown_lfsr16 #(.SEED(LFSR_SEED)) uLfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (st == ST_SCROLL),
    .load    (1'b0),
    .loadVal (LFSR_SEED),
    .state   (lfsr)
  );

  assign floors_y = {fy[0], fy[1], fy[2]};
  assign gaps_x   = {gx[0], gx[1], gx[2]};
  assign gaps_w   = {gw[0], gw[1], gw[2]};
  assign xw       = {1'b0, x_pos};

  // Scroll every floor; floors above the top wrap down with a fresh gap.
  always_comb begin
    nResp = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      gapBits[i] = lfsrAhead(lfsr, i);
      fyScr[i]   = fy[i] - CW'(SCROLL_STEP);
      gxScr[i]   = gx[i];
      gwScr[i]   = gw[i];
      if ({1'b0, fy[i]} < 11'(SCROLL_STEP)) begin
        fyScr[i] = CW'({1'b0, fy[i]} + 11'(RESPAWN_PERIOD - SCROLL_STEP));
        gxScr[i] = CW'(GAP_MIN) + {1'b0, gapBits[i][8:0]};
        gwScr[i] = CW'(GAP_MIN) + {4'b0, gapBits[i][11:9], 3'b0};
        nResp    = nResp + 2'd1;
      end
    end
    scoreSum  = {1'b0, score} + {15'b0, nResp};
    scoreNext = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
  end

  // Horizontal step with edge clamping; conflicting buttons hold position.
  always_comb begin
    xMove = x_pos;
    if (btn_left && !btn_right)
      xMove = (xw < 11'(BALL_R + MOVE_STEP)) ? CW'(BALL_R) : x_pos - CW'(MOVE_STEP);
    else if (btn_right && !btn_left)
      xMove = (xw + 11'(MOVE_STEP) > X_MAX) ? X_MAX[CW-1:0] : x_pos + CW'(MOVE_STEP);
  end

  // Landing: scan low-priority floors first so floor0 wins any tie.
  always_comb begin
    bw      = {1'b0, y_pos} + 11'(BALL_R);
    yw      = {1'b0, y_pos} + 11'(FALL_STEP);
    hit     = 1'b0;
    hitFy   = '0;
    overGap = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      overGap = ({1'b0, gx[i]} <= xw) && (xw < {1'b0, gx[i]} + {1'b0, gw[i]});
      if (({1'b0, fy[i]} <= bw + 11'(FALL_STEP)) &&
          (bw <= {1'b0, fy[i]} + 11'(SCROLL_STEP)) && !overGap) begin
        hit   = 1'b1;
        hitFy = fy[i];
      end
    end
    yLand    = hit ? hitFy - CW'(BALL_R) : ((yw > Y_MAX) ? Y_MAX[CW-1:0] : yw[CW-1:0]);
    landOver = hit && ({1'b0, hitFy} <= 11'(BALL_R));
  end

  // Frame sequencer: one register stage per phase, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_WAIT;
      x_pos     <= X_INIT;
      y_pos     <= Y_INIT;
      score     <= '0;
      game_over <= 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
        fy[i] <= FLOOR_INIT[i];
        gx[i] <= GAPX_INIT[i];
        gw[i] <= GAPW_INIT[i];
      end
    end else begin
      case (st)
        ST_WAIT, ST_OVER: if (start) begin
          st        <= ST_IDLE;
          x_pos     <= X_INIT;
          y_pos     <= Y_INIT;
          score     <= '0;
          game_over <= 1'b0;
          for (int i = 0; i < NUM_FLOORS; i++) begin
            fy[i] <= FLOOR_INIT[i];
            gx[i] <= GAPX_INIT[i];
            gw[i] <= GAPW_INIT[i];
          end
        end
        ST_IDLE: if (frame) st <= ST_SCROLL;
        ST_SCROLL: begin
          for (int i = 0; i < NUM_FLOORS; i++) begin
            fy[i] <= fyScr[i];
            gx[i] <= gxScr[i];
            gw[i] <= gwScr[i];
          end
          score <= scoreNext;
          st    <= ST_MOVE;
        end
        ST_MOVE: begin
          x_pos <= xMove;
          st    <= ST_LAND;
        end
        ST_LAND: begin
          y_pos <= yLand;
          if (landOver) begin
            game_over <= 1'b1;
            st        <= ST_OVER;
          end else begin
            st <= ST_IDLE;
          end
        end
        default: st <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fdown_ctrl.sv
// Scoreboard bench for fdown_ctrl: a behavioural game model predicts each frame.
module tb_fdown_ctrl;
  import fdown_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, frame = 1'b0, start = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0;
  logic [9:0]  x_pos, y_pos;
  logic [29:0] floors_y, gaps_x, gaps_w;
  logic        game_over;
  logic [15:0] score;

  int nChecks = 0, nErrors = 0;

  typedef struct packed {
    logic [9:0]  x, y;
    logic [29:0] fys, gxs, gws;
    logic [15:0] score;
    logic        go;
  } exp_t;
  exp_t sbq [$];

  // behavioural game state
  int          mx, my, mscore;
  int          mfy [3], mgx [3], mgw [3];
  bit          mover, mwait;
  logic [15:0] mlfsr;

  fdown_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .start(start),
    .btn_left(btn_left), .btn_right(btn_right),
    .x_pos(x_pos), .y_pos(y_pos), .floors_y(floors_y),
    .gaps_x(gaps_x), .gaps_w(gaps_w), .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    if (obs !== expv) begin
      nErrors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mStep(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic mLoad();
    mx = 320; my = 240; mscore = 0; mover = 0;
    mfy[0] = 100; mfy[1] = 250; mfy[2] = 400;
    mgx[0] = 200; mgx[1] = 300; mgx[2] = 150;
    mgw[0] = 40;  mgw[1] = 35;  mgw[2] = 60;
  endtask

  task automatic mReset();
    mLoad(); mwait = 1; mlfsr = 16'hACE1;
  endtask

  task automatic mRestart();
    mLoad(); mwait = 0;
  endtask

  task automatic mFrame(input bit l, input bit r);
    logic [15:0] la;
    int b, c;
    if (mwait || mover) return;
    la = mlfsr;
    for (int i = 0; i < 3; i++) begin
      if (mfy[i] < 1) begin
        mfy[i] = mfy[i] + 449;
        mgx[i] = 32 + int'(la[8:0]);
        mgw[i] = 32 + 8 * int'(la[11:9]);
        if (mscore < 65535) mscore++;
      end else mfy[i] = mfy[i] - 1;
      la = mStep(la);
    end
    mlfsr = mStep(mlfsr);
    if (l && !r) mx = (mx - 2 < 8) ? 8 : mx - 2;
    if (r && !l) mx = (mx + 2 > 631) ? 631 : mx + 2;
    b = my + 8; c = -1;
    for (int i = 0; i < 3; i++)
      if (c < 0 && mfy[i] <= b + 2 && b <= mfy[i] + 1 &&
          !(mgx[i] <= mx && mx < mgx[i] + mgw[i])) c = i;
    if (c >= 0) begin
      my = (mfy[c] - 8) & 1023;
      if (mfy[c] <= 8) mover = 1;
    end else my = (my + 2 > 471) ? 471 : my + 2;
  endtask

  function automatic exp_t mPack();
    exp_t e;
    e.x = 10'(mx); e.y = 10'(my);
    e.fys = {10'(mfy[0]), 10'(mfy[1]), 10'(mfy[2])};
    e.gxs = {10'(mgx[0]), 10'(mgx[1]), 10'(mgx[2])};
    e.gws = {10'(mgw[0]), 10'(mgw[1]), 10'(mgw[2])};
    e.score = 16'(mscore); e.go = mover;
    return e;
  endfunction

  task automatic checkOut(input string tag, input exp_t e);
    chk({tag, ".x"},      32'(x_pos),     32'(e.x));
    chk({tag, ".y"},      32'(y_pos),     32'(e.y));
    chk({tag, ".floors"}, 32'(floors_y),  32'(e.fys));
    chk({tag, ".gapsx"},  32'(gaps_x),    32'(e.gxs));
    chk({tag, ".gapsw"},  32'(gaps_w),    32'(e.gws));
    chk({tag, ".score"},  32'(score),     32'(e.score));
    chk({tag, ".over"},   32'(game_over), 32'(e.go));
  endtask

  task automatic doFrame(input bit l, input bit r);
    btn_left = l; btn_right = r;
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
    mFrame(l, r);
    sbq.push_back(mPack());
    repeat (4) @(negedge clk);
    checkOut("frame", sbq.pop_front());
  endtask

  task automatic pulseStart();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    mRestart();
  endtask

  initial begin
    logic [9:0] f0, f1, f2, g0, g1, w0, w1, xOld;

    // reset, then frames are ignored until start
    mReset();
    repeat (2) @(negedge clk);
    checkOut("reset", mPack());
    rst_n = 1'b1;
    repeat (5) doFrame(1'b0, 1'b0);

    // first game, no buttons, played through to game over
    pulseStart();
    for (int f = 1; f <= 395; f++) begin
      doFrame(1'b0, 1'b0);
      f0 = floors_y[FLD0_HI:FLD0_LO];
      f1 = floors_y[FLD1_HI:FLD1_LO];
      f2 = floors_y[FLD2_HI:FLD2_LO];
      g0 = gaps_x[FLD0_HI:FLD0_LO]; w0 = gaps_w[FLD0_HI:FLD0_LO];
      g1 = gaps_x[FLD1_HI:FLD1_LO]; w1 = gaps_w[FLD1_HI:FLD1_LO];
      if (f == 1) begin
        chk("f1_floors", 32'(floors_y), 32'({10'd99, 10'd249, 10'd399}));
        chk("f1_x", 32'(x_pos), 32'd320);
        chk("f1_y", 32'(y_pos), 32'd242);
      end
      if (f == 51) begin
        chk("f51_fy2", 32'(f2), 32'd349);
        chk("f51_y", 32'(y_pos), 32'd341);
      end
      if (f == 52) chk("f52_y", 32'(y_pos), 32'd340);
      if (f == 101) begin
        chk("f101_score", 32'(score), 32'd1);
        chk("f101_fy0", 32'(f0), 32'd449);
        chk("f101_gap0_fit", 32'(32'(g0) + 32'(w0) <= 631), 32'd1);
      end
      if (f == 251) begin
        chk("f251_score", 32'(score), 32'd2);
        chk("f251_fy1", 32'(f1), 32'd449);
        chk("f251_gap1_fit", 32'(32'(g1) + 32'(w1) <= 631), 32'd1);
      end
      if (f == 392) begin
        chk("f392_fy2", 32'(f2), 32'd8);
        chk("f392_over", 32'(game_over), 32'd1);
        chk("f392_score", 32'(score), 32'd2);
      end
    end

    // restart from OVER
    pulseStart();
    repeat (2) @(negedge clk);
    checkOut("restart", mPack());
    chk("restart_score", 32'(score), 32'd0);

    // right held: first frame also checks per-phase update timing
    btn_right = 1'b1;
    xOld = x_pos;
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
    mFrame(1'b0, 1'b1);
    @(negedge clk);
    chk("t_floors_c2", 32'(floors_y), 32'({10'd99, 10'd249, 10'd399}));
    chk("t_x_c2", 32'(x_pos), 32'(xOld));
    @(negedge clk);
    chk("t_x_c3", 32'(x_pos), 32'(mx));
    chk("t_y_c3", 32'(y_pos), 32'd240);
    @(negedge clk);
    chk("t_y_c4", 32'(y_pos), 32'(my));
    for (int f = 2; f <= 200; f++) begin
      doFrame(1'b0, 1'b1);
      chk("x_le_631", 32'(x_pos <= 10'd631), 32'd1);
    end
    chk("x_sat_right", 32'(x_pos), 32'd631);

    // reset asserted mid-sequence, during the move phase
    btn_right = 1'b0;
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mReset();
    checkOut("midreset", mPack());
    @(negedge clk) rst_n = 1'b1;

    // left held in a fresh game
    pulseStart();
    for (int f = 1; f <= 200; f++) begin
      doFrame(1'b1, 1'b0);
      chk("x_ge_8", 32'(x_pos >= 10'd8), 32'd1);
    end
    chk("x_sat_left", 32'(x_pos), 32'd8);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/fdown_ctrl.md
# fdown_ctrl

Per-frame game controller for the fDown falling-ball screen. Once per VGA frame it scrolls the three floors upward, moves the ball from button input, and applies gravity and floor collision. It also respawns off-screen floors with pseudo-random gaps and detects game over. Its outputs drive the ball and floor renderers directly; it runs in the pixel-clock domain beside the VGA timing generator.

## Interface
- SCROLL_STEP, 1: floor rise per frame (px)
- FALL_STEP, 2: ball fall per frame (px)
- MOVE_STEP, 2: ball horizontal step per frame (px)
- BALL_R, 8: ball half-size (px)
- LFSR_SEED, 16'hACE1: gap generator seed, nonzero
- clk  in  1  pixel clock, the same clock as the VGA generator
- rst_n  in  1  reset; asynchronous, active-low
- frame  in  1  one-cycle pulse per frame, from the VGA generator
- start  in  1  level; starts or restarts a game
- btn_left, btn_right  in  1  debounced levels
- x_pos, y_pos  out  10  ball centre
- floors_y  out  30  floor Y: floor0 in [29:20], floor1 in [19:10], floor2 in [9:0]
- gaps_x  out  30  gap left edge for each floor, same packing
- gaps_w  out  30  gap width for each floor, same packing
- game_over  out  1
- score  out  16  count of floors respawned, saturates at 16'hFFFF

## Operation
- Reset and restart values:
  - x=320, y=240
  - floors_y={100,250,400}, gaps_x={200,300,150}, gaps_w={40,35,60}
  - score=0, game_over=0
  - LFSR=LFSR_SEED
- A restart restores all of these values except the LFSR.
- States are WAIT, IDLE, SCROLL, MOVE, LAND and OVER.
  - WAIT: start→IDLE.
  - IDLE: frame→SCROLL.
  - SCROLL→MOVE→LAND→IDLE, or LAND→OVER.
  - OVER: start→IDLE, with restart values loaded.
- frame is ignored outside IDLE.
- SCROLL, per floor i:
  - If fy_i < SCROLL_STEP, the floor respawns: fy_i = fy_i + 450 − SCROLL_STEP.
  - On respawn, gap_x = 32 + lfsr[8:0] (range 32..543) and gap_w = 32 + {lfsr[11:9],3'b0} (range 32..88).
  - On respawn, score increments.
  - Otherwise fy_i −= SCROLL_STEP.
  - The LFSR advances once per SCROLL: x^16+x^14+x^13+x^11+1, Fibonacci, shifting left.
  - Floor i uses LFSR bits after i shifts. The implementation may compute all three as a combinational look-ahead.
- MOVE:
  - left only: x −= MOVE_STEP, clamped to ≥ BALL_R.
  - right only: x += MOVE_STEP, clamped to ≤ 639−BALL_R.
  - both or neither: x is held.
- LAND, using post-scroll floors and b = y + BALL_R:
  - Floor i catches the ball if fy_i ≤ b+FALL_STEP, b ≤ fy_i+SCROLL_STEP, and the ball is not over the gap. "Over the gap" means gap_x_i ≤ x < gap_x_i+gap_w_i.
  - Priority is floor0 > floor1 > floor2.
  - If caught: y = fy_i − BALL_R; if fy_i ≤ BALL_R, the next state is OVER and game_over=1.
  - If not caught: y = min(y+FALL_STEP, 479−BALL_R).
- All comparisons are made at 11 bits unsigned so no intermediate sum overflows.
- In OVER, every output is frozen and game_over=1.

## Timing
- frame is sampled in IDLE at cycle 0.
- floors_y, gaps and score update at the edge ending cycle 1.
- x_pos updates at the edge ending cycle 2.
- y_pos and game_over update at the edge ending cycle 3.
- Outputs are stable from cycle 4 until the next frame.
- Every output is a register; there is no combinational path from inputs to outputs.
- start is sampled only in WAIT and OVER.
- Buttons are sampled only in MOVE.
- rst_n low at any point, including mid-sequence, immediately forces the reset values and state WAIT.

## Structure
- Shared package fdown_pkg holds:
  - state enum
  - reset and restart position and gap constants
  - screen extents 640/480
  - respawn period 450
  - field-slice constants for the 30-bit packing
- One sub-module, fdown_lfsr16: 16-bit LFSR with an advance enable and a synchronous load.

## Test plan
- Reset then 5 frame pulses without start → all outputs at reset values, game_over=0.
- start, then 1 frame, no buttons → floors_y={99,249,399}, x=320 (inside floor1 gap 300..334), y=242.
- start, right held 200 frames → x saturates at 631 and never exceeds it. Left held → x saturates at 8.
- start, no buttons → at frame 51 the ball lands on floor2 (fy=349), y=341. At frame 52, y=340.
- Continuing → floor0 respawns at frame 101 (score=1, fy0=449) and floor1 at frame 251 (score=2).
  - Gaps match the LFSR reference model; gap_x+gap_w ≤ 631.
- Continuing → frame 392 (fy2=8) gives game_over=1 and score=2. Further frames change nothing. start restores the restart values with score=0.
- rst_n asserted at cycle 2 after a frame pulse → all outputs return to reset values asynchronously.
